// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes and the
// write-port arbitration function used for array writes, bypass and conflicts.
package regfile_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 5;
   localparam int MAX_WR     = 4;
   localparam int MAX_ADDR_W = 16;
   localparam int IDX_W      = 2;

   typedef logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr_vec_t;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] win;
      logic             multi;
   } wr_arb_t;

   // Ascending scan: every later hit overwrites win, so the highest enabled
   // port index always wins a shared address.
   function automatic wr_arb_t wr_arbitrate(input logic [MAX_WR-1:0] en,
                                            input wr_addr_vec_t      addr,
                                            input logic [MAX_ADDR_W-1:0] cand);
      wr_arb_t res;
      res = '0;
      for (int j = 0; j < MAX_WR; j++) begin
         if (en[j] && (addr[j] == cand)) begin
            res.multi = res.multi | res.hit;
            res.hit   = 1'b1;
            res.win   = IDX_W'(j);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Arbitrates all write ports against one candidate address: reports a hit,
// the winning (highest-index) port and whether more than one port matched.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int NUM_WR = 2,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0]        cand,
   output logic                     hit,
   output logic [IDX_W-1:0]         win,
   output logic                     multi
);

   logic [MAX_WR-1:0] en_ext;
   wr_addr_vec_t      addr_ext;
   wr_arb_t           res;

   // Widen to the package's maximum port count; unused ports stay disabled.
   always_comb begin
      en_ext   = '0;
      addr_ext = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         en_ext[j]   = wr_en[j];
         addr_ext[j] = MAX_ADDR_W'(wr_addr[j*ADDR_W +: ADDR_W]);
      end
      res = wr_arbitrate(en_ext, addr_ext, MAX_ADDR_W'(cand));
   end

   assign hit   = res.hit;
   assign win   = res.win;
   assign multi = res.multi;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with fixed write priority, optional
// zero register, write-to-read bypass, registered reads and a conflict counter.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 4,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int READ_LAT = 0,
   parameter int CNT_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     conflict_clr,
   output logic                     conflict_flag,
   output logic [CNT_W-1:0]         conflict_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]        mem    [DEPTH];
   logic [DATA_W-1:0]        wdat   [MAX_WR];
   logic [IDX_W-1:0]         wr_win [DEPTH];
   logic [DEPTH-1:0]         wr_hit;
   logic [DEPTH-1:0]         wr_multi;
   logic [DEPTH-1:0]         conf_mask;
   logic [NUM_RD*DATA_W-1:0] rd_next;
   logic                     conflict;

   // Pad the write data to the full arbiter index range so a winner index can
   // select it directly.
   for (genvar wj = 0; wj < MAX_WR; wj++) begin : g_wdat
      if (wj < NUM_WR) begin : g_used
         assign wdat[wj] = wr_data[wj*DATA_W +: DATA_W];
      end else begin : g_pad
         assign wdat[wj] = '0;
      end
   end

   for (genvar a = 0; a < DEPTH; a++) begin : g_addr
      regfile_wr_arb #(
         .NUM_WR (NUM_WR),
         .ADDR_W (ADDR_W)
      ) u_arb (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .cand    (ADDR_W'(a)),
         .hit     (wr_hit[a]),
         .win     (wr_win[a]),
         .multi   (wr_multi[a])
      );
   end

   // Colliding writes to the hardwired zero register are harmless and ignored.
   always_comb begin
      conf_mask = wr_multi;
      if (ZERO_REG != 0) begin
         conf_mask[0] = 1'b0;
      end
   end

   assign conflict = |conf_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) begin
            mem[a] <= '0;
         end
      end else begin
         for (int a = 0; a < DEPTH; a++) begin
            if (wr_hit[a] && !((ZERO_REG != 0) && (a == 0))) begin
               mem[a] <= wdat[wr_win[a]];
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              byp_hit;
      logic [IDX_W-1:0]  byp_win;
      logic              byp_multi_unused;
      logic [DATA_W-1:0] val;

      assign ra = rd_addr[i*ADDR_W +: ADDR_W];

      regfile_wr_arb #(
         .NUM_WR (NUM_WR),
         .ADDR_W (ADDR_W)
      ) u_byp (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .cand    (ra),
         .hit     (byp_hit),
         .win     (byp_win),
         .multi   (byp_multi_unused)
      );

      // Zero register check comes last so it overrides a forwarded write.
      always_comb begin
         val = mem[ra];
         if ((BYPASS != 0) && byp_hit) begin
            val = wdat[byp_win];
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            val = '0;
         end
      end

      assign rd_next[i*DATA_W +: DATA_W] = val;
   end

   if (READ_LAT != 0) begin : g_lat
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data <= '0;
         end else begin
            rd_data <= rd_next;
         end
      end
   end else begin : g_comb
      assign rd_data = rd_next;
   end

   // Clear beats a simultaneous conflict; the count saturates at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_flag <= 1'b0;
         conflict_cnt  <= '0;
      end else if (conflict_clr) begin
         conflict_flag <= 1'b0;
         conflict_cnt  <= '0;
      end else if (conflict) begin
         conflict_flag <= 1'b1;
         if (conflict_cnt != {CNT_W{1'b1}}) begin
            conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, the next generation of the team's fixed 4-read/2-write 64-bit register file.
- Each read port has its own address. Each write port has its own address, data and enable.
- Features:
  - deterministic priority between write ports that hit the same register;
  - optional hardwired-zero register 0;
  - optional write-to-read bypass;
  - optional registered reads;
  - a saturating counter for write conflicts.
- Sits between decode (read addresses) and writeback (write ports) in the datapath.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 4, number of read ports (1..8).
- NUM_WR, 2, number of write ports (1..4).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a write in the current cycle is forwarded to same-address reads.
- READ_LAT, 0, 0 = combinational read; 1 = read data registered (one-cycle latency).
- CNT_W, 8, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses, packed as for rd_addr.
- wr_data  in  NUM_WR*DATA_W  write data, packed as for rd_data.
- conflict_clr  in  1  synchronous clear of conflict_cnt and conflict_flag.
- conflict_flag  out  1  sticky; set when any write conflict occurs.
- conflict_cnt  out  CNT_W  saturating count of cycles with at least one write conflict.

Behaviour:
- Reset (rst high, asynchronous):
  - all 2**ADDR_W registers = 0;
  - conflict_cnt = 0 and conflict_flag = 0;
  - if READ_LAT=1, rd_data = 0;
  - if READ_LAT=0, rd_data = 0 follows from the cleared array.
- Write, at the rising edge, for each port j with wr_en[j]=1: register[wr_addr[j]] <= wr_data[j].
- Write priority: if two or more enabled ports target the same address, the highest-index port wins. This rule is fixed and is not order-of-statements accidental.
- Write conflict:
  - Definition: in one cycle, two or more enabled ports share an address, excluding address 0 when ZERO_REG=1.
  - On a conflict edge: conflict_flag <= 1 and conflict_cnt <= conflict_cnt+1, saturating at 2**CNT_W-1.
  - Multiple colliding pairs in one cycle count once.
  - conflict_clr=1 at an edge zeroes both outputs. If a conflict occurs in the same cycle, clear wins and the conflict is not counted.
- ZERO_REG=1: writes to address 0 are discarded, and reads of address 0 return 0 regardless of bypass.
- Read, READ_LAT=0:
  - rd_data[i] = register[rd_addr[i]], combinational.
  - If BYPASS=1 and an enabled write port targets rd_addr[i] this cycle, return the winning write data instead (write-first).
  - If BYPASS=0, return the old contents; the new value is visible from the next cycle.
- Read, READ_LAT=1:
  - The value computed as for READ_LAT=0 is captured at the edge and appears one cycle after the address.
  - With BYPASS=0, a same-cycle write is not visible; the old value is captured.
- Ports are fully independent: any number of read ports may share an address.
- Out-of-range addresses cannot occur, because depth is exactly 2**ADDR_W.
- Reset mid-operation: the array and outputs clear immediately; no write completes in the edge coincident with rst high.

Decomposition:
- Package regfile_pkg:
  - default DATA_W and ADDR_W;
  - a function that converts a write-enable/address vector into a per-address winning-port index plus a conflict bit.
- Sub-module regfile_wr_arb: for one candidate address, takes wr_en/wr_addr and outputs hit, winning port index and multi-hit.
  - Instantiated once for the bypass path of each read port.
  - Reused by the array write logic and by the conflict detector.

Test Plan:
1. Reset, then write port 0 with addr 3 = 0x1111111111111111 and read port 2 at addr 3 on the next cycle -> rd_data port 2 = 0x1111111111111111; all other read ports at addr 5 -> 0.
2. Ports 0 and 1 both write addr 1 (0x3333…, 0x4444…) in the same edge -> addr 1 reads 0x4444…; conflict_flag=1; conflict_cnt=1.
3. BYPASS=1, READ_LAT=0: write addr 7 = 0xA5A5… while read port 0 is at addr 7 in the same cycle -> rd_data port 0 = 0xA5A5… in that cycle. Repeat with BYPASS=0 -> old value 0 in that cycle, 0xA5A5… in the next.
4. ZERO_REG=1: write addr 0 = 0xFFFF… on both ports -> addr 0 reads 0; conflict_cnt unchanged.
5. CNT_W=2: force 5 conflict cycles -> conflict_cnt saturates at 3. Then conflict_clr together with a conflict -> conflict_cnt=0 and conflict_flag=0.
6. READ_LAT=1: issue an address at cycle n -> data at cycle n+1. Assert rst asynchronously mid-cycle -> rd_data = 0 immediately, and all registers read 0 afterwards.
